mp_wr_arbiter: RTL and testbench

MP_WR_ARBITER -- requirements
Module: mp_wr_arbiter

---
 rtl/mp_wr_arbiter.sv | 154 +++++++++++++++
 tb/tb_mp_wr_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_wr_arbiter.sv
// Multi-port packet write arbiter: round-robin packet grant onto one cache bus.
// Optional watchdog abort of stalled packets enabled by MP_ARB_WATCHDOG_EN.
module mp_wr_arbiter #(
    parameter int IN_PORT_NUM = 16,
    parameter int DATA_WIDTH  = 32,
    localparam int PW = (IN_PORT_NUM > 1) ? $clog2(IN_PORT_NUM) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n_in,
    input  logic [IN_PORT_NUM-1:0]            wr_sop,
    input  logic [IN_PORT_NUM-1:0]            wr_eop,
    input  logic [IN_PORT_NUM-1:0]            wr_vld,
    input  logic [IN_PORT_NUM*DATA_WIDTH-1:0] wr_data,
    input  logic                              full,
    input  logic                              almost_full,
    output logic [IN_PORT_NUM-1:0]            ready,
    output logic                              out_sop,
    output logic                              out_eop,
    output logic                              out_vld,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [PW-1:0]                     out_port,
    output logic                              sop_err,
    output logic                              wd_timeout
);

    typedef enum logic {
        IDLE,
        PKT
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   g_q, g_d;
    logic [PW-1:0]   p_q, p_d;
    logic [PW-1:0]   g_inc;
    logic [PW-1:0]   pick;
    logic [PW:0]     scan;
    logic            found;
    logic            first_q;
    logic            acc;
    logic            sop_g;
    logic            eop_g;
    logic [DATA_WIDTH-1:0] data_g;
    logic [IN_PORT_NUM-1:0] req;
    logic            wd_hit;

    assign req    = wr_vld & wr_sop;
    assign sop_g  = wr_sop[g_q];
    assign eop_g  = wr_eop[g_q];
    assign data_g = wr_data[g_q*DATA_WIDTH +: DATA_WIDTH];
    assign acc    = (state_q == PKT) & wr_vld[g_q] & ~full;
    assign g_inc  = (g_q == PW'(IN_PORT_NUM-1)) ? '0 : g_q + 1'b1;

    always_comb begin
        ready = '0;
        if (state_q == PKT) ready[g_q] = ~full;
    end

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        scan  = '0;
        for (int i = 0; i < IN_PORT_NUM; i++) begin
            scan = {1'b0, p_q} + (PW+1)'(i);
            if (scan >= (PW+1)'(IN_PORT_NUM))
                scan = scan - (PW+1)'(IN_PORT_NUM);
            if (!found && req[scan[PW-1:0]]) begin
                found = 1'b1;
                pick  = scan[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        p_d     = p_q;
        unique case (state_q)
            IDLE: begin
                if (found && !almost_full && !full) begin
                    state_d = PKT;
                    g_d     = pick;
                end
            end
            PKT: begin
                if ((acc && eop_g) || wd_hit) begin
                    state_d = IDLE;
                    p_d     = g_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            g_q     <= '0;
            p_q     <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            p_q     <= p_d;
            if (state_q == IDLE && state_d == PKT)
                first_q <= 1'b1;
            else if (acc)
                first_q <= 1'b0;
        end
    end

`ifdef MP_ARB_WATCHDOG_EN
    logic [7:0] wd_cnt_q;
    logic       stall;

    assign stall  = (state_q == PKT) & ~full & ~acc;
    // The 255th consecutive idle-but-open cycle aborts the packet.
    assign wd_hit = stall & (wd_cnt_q == 8'd254);

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in)
            wd_cnt_q <= '0;
        else if (state_q != PKT || acc || wd_hit)
            wd_cnt_q <= '0;
        else if (stall)
            wd_cnt_q <= wd_cnt_q + 8'd1;
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_vld    <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_data   <= '0;
            out_port   <= '0;
            sop_err    <= 1'b0;
            wd_timeout <= 1'b0;
        end else begin
            out_vld    <= acc;
            out_sop    <= acc & sop_g;
            out_eop    <= acc & eop_g;
            sop_err    <= acc & sop_g & ~first_q;
            wd_timeout <= wd_hit;
            if (acc) begin
                out_data <= data_g;
                out_port <= g_q;
            end
        end
    end

endmodule

// File: tb/tb_mp_wr_arbiter.sv
// Directed self-checking bench for mp_wr_arbiter (16 ports, 32-bit data).
// Watchdog checks follow MP_ARB_WATCHDOG_EN when it is defined.
module tb_mp_wr_arbiter;

    localparam int N = 16;
    localparam int W = 32;

    logic           clk;
    logic           rst_n_in;
    logic [N-1:0]   wr_sop;
    logic [N-1:0]   wr_eop;
    logic [N-1:0]   wr_vld;
    logic [N*W-1:0] wr_data;
    logic           full;
    logic           almost_full;
    logic [N-1:0]   ready;
    logic           out_sop;
    logic           out_eop;
    logic           out_vld;
    logic [W-1:0]   out_data;
    logic [3:0]     out_port;
    logic           sop_err;
    logic           wd_timeout;

    int total;
    int bad;

    mp_wr_arbiter #(
        .IN_PORT_NUM(N),
        .DATA_WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n_in   (rst_n_in),
        .wr_sop     (wr_sop),
        .wr_eop     (wr_eop),
        .wr_vld     (wr_vld),
        .wr_data    (wr_data),
        .full       (full),
        .almost_full(almost_full),
        .ready      (ready),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_vld    (out_vld),
        .out_data   (out_data),
        .out_port   (out_port),
        .sop_err    (sop_err),
        .wd_timeout (wd_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rdy(input string tag, input logic [N-1:0] exp);
        #1;
        chk(tag, 64'(ready), 64'(exp));
    endtask

    task automatic chk_out(input string tag, input logic [3:0] port,
                           input logic [31:0] data, input logic sop,
                           input logic eop);
        chk({tag, "_vld"}, 64'(out_vld), 64'd1);
        chk({tag, "_port"}, 64'(out_port), 64'(port));
        chk({tag, "_data"}, 64'(out_data), 64'(data));
        chk({tag, "_sop"}, 64'(out_sop), 64'(sop));
        chk({tag, "_eop"}, 64'(out_eop), 64'(eop));
    endtask

    task automatic drv(input int p, input logic v, input logic s,
                       input logic e, input logic [31:0] d);
        wr_vld[p] = v;
        wr_sop[p] = s;
        wr_eop[p] = e;
        wr_data[p*W +: W] = d;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n_in    = 1'b1;
        wr_sop      = '0;
        wr_eop      = '0;
        wr_vld      = '0;
        wr_data     = '0;
        full        = 1'b0;
        almost_full = 1'b0;
        #3 rst_n_in = 1'b0;
        #1;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_vld", 64'(out_vld), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_port", 64'(out_port), 64'd0);
        chk("rst_sop_err", 64'(sop_err), 64'd0);
        chk("rst_wd", 64'(wd_timeout), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n_in = 1'b1;

        // Ports 0,3,5 request together, 2-beat packets.
        drv(0, 1, 1, 0, 32'h01);
        drv(3, 1, 1, 0, 32'h30);
        drv(5, 1, 1, 0, 32'h50);
        chk_rdy("rr_idle_rdy", 16'h0000);
        cyc();
        chk_rdy("rr_g0_rdy", 16'h0001);
        chk("rr_g0_novld", 64'(out_vld), 64'd0);
        cyc();
        drv(0, 1, 0, 1, 32'h02);
        chk_out("rr_b0", 4'd0, 32'h01, 1, 0);
        cyc();
        drv(0, 0, 0, 0, 32'h0);
        chk_out("rr_b1", 4'd0, 32'h02, 0, 1);
        chk_rdy("rr_idle2_rdy", 16'h0000);
        cyc();
        chk_rdy("rr_g3_rdy", 16'h0008);
        chk("rr_gap3", 64'(out_vld), 64'd0);
        cyc();
        drv(3, 1, 0, 1, 32'h31);
        chk_out("rr_b2", 4'd3, 32'h30, 1, 0);
        cyc();
        drv(3, 0, 0, 0, 32'h0);
        chk_out("rr_b3", 4'd3, 32'h31, 0, 1);
        cyc();
        chk_rdy("rr_g5_rdy", 16'h0020);
        cyc();
        drv(5, 1, 0, 1, 32'h51);
        chk_out("rr_b4", 4'd5, 32'h50, 1, 0);
        cyc();
        drv(5, 0, 0, 0, 32'h0);
        chk_out("rr_b5", 4'd5, 32'h51, 0, 1);

        // Pointer now 6: ports 4 and 6 compete, 6 wins.
        drv(4, 1, 1, 1, 32'h44);
        drv(6, 1, 1, 1, 32'h66);
        cyc();
        chk_rdy("p6_rdy", 16'h0040);
        cyc();
        drv(6, 0, 0, 0, 32'h0);
        chk_out("p6_out", 4'd6, 32'h66, 1, 1);

        // Single-beat packet on port 4 after wrap.
        drv(4, 1, 1, 1, 32'hA5A5A5A5);
        cyc();
        chk_rdy("sb_rdy", 16'h0010);
        cyc();
        drv(4, 0, 0, 0, 32'h0);
        chk_out("sb_out", 4'd4, 32'hA5A5A5A5, 1, 1);
        chk_rdy("sb_idle", 16'h0000);

        // Port 2, 4 beats, full on the 2nd data cycle; port 9 noise.
        drv(2, 1, 1, 0, 32'h20);
        cyc();
        chk_rdy("fl_rdy", 16'h0004);
        cyc();
        drv(2, 1, 0, 0, 32'h21);
        drv(9, 1, 1, 1, 32'hDEAD);
        full = 1'b1;
        chk_rdy("fl_full_rdy", 16'h0000);
        chk_out("fl_b0", 4'd2, 32'h20, 1, 0);
        cyc();
        full = 1'b0;
        chk("fl_gap", 64'(out_vld), 64'd0);
        chk_rdy("fl_resume_rdy", 16'h0004);
        cyc();
        drv(2, 1, 0, 0, 32'h22);
        chk_out("fl_b1", 4'd2, 32'h21, 0, 0);
        cyc();
        drv(2, 1, 0, 1, 32'h23);
        drv(9, 0, 0, 0, 32'h0);
        chk_out("fl_b2", 4'd2, 32'h22, 0, 0);
        cyc();
        drv(2, 0, 0, 0, 32'h0);
        chk_out("fl_b3", 4'd2, 32'h23, 0, 1);

        // almost_full blocks admission but not an open packet.
        almost_full = 1'b1;
        drv(1, 1, 1, 0, 32'h10);
        cyc();
        chk_rdy("af_hold1", 16'h0000);
        cyc();
        chk_rdy("af_hold2", 16'h0000);
        almost_full = 1'b0;
        cyc();
        chk_rdy("af_grant", 16'h0002);
        almost_full = 1'b1;
        cyc();
        drv(1, 1, 0, 1, 32'h11);
        chk_rdy("af_mid_rdy", 16'h0002);
        chk_out("af_b0", 4'd1, 32'h10, 1, 0);
        cyc();
        drv(1, 0, 0, 0, 32'h0);
        almost_full = 1'b0;
        chk_out("af_b1", 4'd1, 32'h11, 0, 1);

        // Port 7: stray sop on beat 3.
        drv(7, 1, 1, 0, 32'h70);
        cyc();
        chk_rdy("se_rdy", 16'h0080);
        cyc();
        drv(7, 1, 0, 0, 32'h71);
        chk("se_err0", 64'(sop_err), 64'd0);
        cyc();
        drv(7, 1, 1, 0, 32'h72);
        chk("se_err1", 64'(sop_err), 64'd0);
        cyc();
        drv(7, 1, 0, 1, 32'h73);
        chk_out("se_b2", 4'd7, 32'h72, 1, 0);
        chk("se_err2", 64'(sop_err), 64'd1);
        cyc();
        drv(7, 0, 0, 0, 32'h0);
        chk("se_err3", 64'(sop_err), 64'd0);
        chk_out("se_b3", 4'd7, 32'h73, 0, 1);

        // Reset mid-packet on port 9, then restart from port 0.
        drv(9, 1, 1, 0, 32'h90);
        cyc();
        cyc();
        drv(9, 1, 0, 1, 32'h91);
        chk("mr_pre_vld", 64'(out_vld), 64'd1);
        rst_n_in = 1'b0;
        chk_rdy("mr_rdy", 16'h0000);
        chk("mr_vld", 64'(out_vld), 64'd0);
        chk("mr_data", 64'(out_data), 64'd0);
        cyc();
        rst_n_in = 1'b1;
        drv(9, 1, 1, 1, 32'h9A);
        drv(3, 1, 1, 1, 32'h3A);
        cyc();
        chk_rdy("mr_regrant", 16'h0008);
        drv(9, 0, 0, 0, 32'h0);
        cyc();
        drv(3, 0, 0, 0, 32'h0);
        chk_out("mr_out", 4'd3, 32'h3A, 1, 1);

        // Port 6 granted, then stalls with full=0.
        drv(6, 1, 1, 0, 32'h6A);
        cyc();
        chk_rdy("wd_grant", 16'h0040);
        drv(6, 0, 0, 0, 32'h0);
`ifdef MP_ARB_WATCHDOG_EN
        repeat (254) cyc();
        chk("wd_pre", 64'(wd_timeout), 64'd0);
        chk_rdy("wd_pre_rdy", 16'h0040);
        cyc();
        chk("wd_pulse", 64'(wd_timeout), 64'd1);
        chk_rdy("wd_idle", 16'h0000);
        cyc();
        chk("wd_once", 64'(wd_timeout), 64'd0);
        drv(5, 1, 1, 1, 32'h5A);
        drv(7, 1, 1, 1, 32'h7A);
        cyc();
        chk_rdy("wd_p7", 16'h0080);
        drv(5, 0, 0, 0, 32'h0);
        drv(7, 0, 0, 0, 32'h0);
        cyc();
`else
        repeat (300) cyc();
        chk("nwd_pulse", 64'(wd_timeout), 64'd0);
        chk_rdy("nwd_rdy", 16'h0040);
        drv(6, 1, 0, 1, 32'h6B);
        cyc();
        drv(6, 0, 0, 0, 32'h0);
        chk_out("nwd_out", 4'd6, 32'h6B, 0, 1);
        chk_rdy("nwd_idle", 16'h0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
